extmem_arbiter: RTL and testbench

// - Shares the single external-memory port of inverted_residual_block between N_REQ requesters.
// - Requesters: FMI/KEX/KPW/KDW load DMA channels and the FMO write-back path.
// - Round-robin arbitration; one transaction in flight at a time.
// - Reads are blocking until valid_extmem; writes are posted with a one-cycle request.

---
 rtl/extmem_arbiter_if.sv | 41 ++++
 rtl/extmem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_extmem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/extmem_arbiter_if.sv
// Bundle of the arbiter's requester-side and external-memory-side signals.
//   Requester side : req_i, we_i, addr_i, wdata_i  -> arbiter
//                    gnt_o, rvalid_o, rdata_o, rerr_o, busy_o <- arbiter
//   Memory side    : request_extmem, write_extmem, addr_extmem, w_data <- arbiter
//                    valid_extmem, data_extmem -> arbiter
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters + external memory)
interface extmem_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ-1:0]        we_i;
  logic [N_REQ*ADDR_W-1:0] addr_i;
  logic [N_REQ*DATA_W-1:0] wdata_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ-1:0]        rvalid_o;
  logic [DATA_W-1:0]       rdata_o;
  logic                    rerr_o;
  logic                    busy_o;
  logic                    request_extmem;
  logic                    write_extmem;
  logic [ADDR_W-1:0]       addr_extmem;
  logic [DATA_W-1:0]       w_data;
  logic                    valid_extmem;
  logic [DATA_W-1:0]       data_extmem;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, valid_extmem, data_extmem,
    output gnt_o, rvalid_o, rdata_o, rerr_o, busy_o,
    output request_extmem, write_extmem, addr_extmem, w_data
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, valid_extmem, data_extmem,
    input  gnt_o, rvalid_o, rdata_o, rerr_o, busy_o,
    input  request_extmem, write_extmem, addr_extmem, w_data
  );
endinterface

// File: rtl/extmem_arbiter.sv
// Round-robin arbiter sharing one external-memory port between N_REQ requesters.
// One transaction in flight at a time: writes are posted (one request cycle),
// reads block until valid_extmem. All outputs are registered.
// Ports:
//   clk - clock, all logic on posedge
//   rst - synchronous active-low reset
//   bus - extmem_arbiter_if.slave (requester handshake + external memory port)
// Optional feature: define EXTMEM_ARB_TIMEOUT_EN to abort reads that get no
// valid_extmem within TO_CYC cycles (rvalid_o pulses with rerr_o=1, rdata_o=0).
module extmem_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TO_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  extmem_arbiter_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StWr, StRdWait} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   owner_q, owner_d;

  logic              win_valid;
  logic [PtrW-1:0]   win_idx;
  logic              rd_done;
  logic              rd_err;

  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_ext_q, req_ext_d;
  logic              wr_ext_q, wr_ext_d;
  logic              busy_q, busy_d;
  logic              rerr_q, rerr_d;

  // (base + off) mod N_REQ without relying on a power-of-two N_REQ.
  function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PtrW'(s);
  endfunction

  // Winner: first set request scanning upward from ptr_q, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_valid && bus.req_i[wrap_add(ptr_q, i)]) begin
        win_valid = 1'b1;
        win_idx   = wrap_add(ptr_q, i);
      end
    end
  end

  assign rd_done = (state_q == StRdWait) && bus.valid_extmem;

`ifdef EXTMEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // valid_extmem in the expiry cycle takes priority via rd_done.
  assign rd_err = (state_q == StRdWait) && !bus.valid_extmem &&
                  (cnt_q == CntW'(TO_CYC - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == StRdWait && !rd_done && !rd_err) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign rd_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = bus.we_i[win_idx] ? StWr : StRdWait;
          ptr_d   = wrap_add(win_idx, 1);
          owner_d = win_idx;
        end
      end
      StWr:     state_d = StIdle;
      StRdWait: if (rd_done || rd_err) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic: next values of the output registers.
  always_comb begin
    gnt_d     = '0;
    rvalid_d  = '0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    req_ext_d = 1'b0;
    wr_ext_d  = 1'b0;
    rerr_d    = rerr_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          gnt_d[win_idx] = 1'b1;
          addr_d         = bus.addr_i[32'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d        = bus.wdata_i[32'(win_idx)*DATA_W +: DATA_W];
          req_ext_d      = 1'b1;
          wr_ext_d       = bus.we_i[win_idx];
        end
      end
      StWr: ;  // the single write cycle ends; request drops
      StRdWait: begin
        req_ext_d = 1'b1;
        if (rd_done) begin
          rvalid_d[owner_q] = 1'b1;
          rdata_d           = bus.data_extmem;
          rerr_d            = 1'b0;
          req_ext_d         = 1'b0;
        end else if (rd_err) begin
          rvalid_d[owner_q] = 1'b1;
          rdata_d           = '0;
          rerr_d            = 1'b1;
          req_ext_d         = 1'b0;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q     <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ext_q <= 1'b0;
      wr_ext_q  <= 1'b0;
      busy_q    <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      req_ext_q <= req_ext_d;
      wr_ext_q  <= wr_ext_d;
      busy_q    <= busy_d;
      rerr_q    <= rerr_d;
    end
  end

  assign bus.gnt_o          = gnt_q;
  assign bus.rvalid_o       = rvalid_q;
  assign bus.rdata_o        = rdata_q;
  assign bus.busy_o         = busy_q;
  assign bus.request_extmem = req_ext_q;
  assign bus.write_extmem   = wr_ext_q;
  assign bus.addr_extmem    = addr_q;
  assign bus.w_data         = wdata_q;
`ifdef EXTMEM_ARB_TIMEOUT_EN
  assign bus.rerr_o         = rerr_q;
`else
  assign bus.rerr_o         = 1'b0;
`endif

endmodule

// File: tb/tb_extmem_arbiter.sv
// Self-checking bench for extmem_arbiter: a transaction-level model predicts
// every output each cycle; directed tests add hand-computed literal checks.
module tb_extmem_arbiter;
  localparam int N = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  extmem_arbiter_if #(.N_REQ(N), .ADDR_W(32), .DATA_W(32)) bus ();

  extmem_arbiter #(.N_REQ(N), .ADDR_W(32), .DATA_W(32), .TO_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [3:0]  e_gnt, e_rvalid;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic        e_rerr, e_busy, e_req, e_wr;
  int          m_ptr, m_owner, m_kind, m_age;  // m_kind: 0 none, 1 write, 2 read
  bit          mdl_ok = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_addr = '0; e_wdata = '0;
      e_rerr = 1'b0; e_busy = 1'b0; e_req = 1'b0; e_wr = 1'b0;
      m_ptr = 0; m_owner = 0; m_kind = 0; m_age = 0;
    end else begin
      e_gnt = '0; e_rvalid = '0; e_req = 1'b0; e_wr = 1'b0;
      if (m_kind == 0) begin
        int w;
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && bus.req_i[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
          e_gnt[w] = 1'b1;
          e_req    = 1'b1;
          e_wr     = bus.we_i[w];
          e_addr   = bus.addr_i[w*32 +: 32];
          e_wdata  = bus.wdata_i[w*32 +: 32];
          m_ptr    = (w + 1) % N;
          m_owner  = w;
          m_kind   = bus.we_i[w] ? 1 : 2;
          m_age    = 0;
        end
      end else if (m_kind == 1) begin
        m_kind = 0;
      end else begin
        if (bus.valid_extmem) begin
          e_rvalid[m_owner] = 1'b1;
          e_rdata = bus.data_extmem;
          e_rerr  = 1'b0;
          m_kind  = 0;
`ifdef EXTMEM_ARB_TIMEOUT_EN
        end else if (m_age + 1 == TO) begin
          e_rvalid[m_owner] = 1'b1;
          e_rdata = '0;
          e_rerr  = 1'b1;
          m_kind  = 0;
`endif
        end else begin
          m_age++;
          e_req = 1'b1;
        end
      end
      e_busy = (m_kind != 0);
    end
    mdl_ok = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("gnt",      64'(bus.gnt_o),          64'(e_gnt));
      chk("rvalid",   64'(bus.rvalid_o),       64'(e_rvalid));
      chk("rdata",    64'(bus.rdata_o),        64'(e_rdata));
      chk("rerr",     64'(bus.rerr_o),         64'(e_rerr));
      chk("busy",     64'(bus.busy_o),         64'(e_busy));
      chk("req_ext",  64'(bus.request_extmem), 64'(e_req));
      chk("wr_ext",   64'(bus.write_extmem),   64'(e_wr));
      chk("addr_ext", 64'(bus.addr_extmem),    64'(e_addr));
      chk("w_data",   64'(bus.w_data),         64'(e_wdata));
      chk("gnt_onehot",    64'($countones(bus.gnt_o) <= 1), 64'(1));
      chk("rvalid_onehot", 64'($countones(bus.rvalid_o) <= 1), 64'(1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_gnt(output int w);
    w = -1;
    for (int n = 0; n < 20 && w < 0; n++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if (bus.gnt_o[k]) w = k;
    end
    if (w < 0) chk("gnt_wait_expired", 64'(0), 64'(1));
  endtask

  initial begin
    int w;
    int order[6];
    order = '{0, 1, 3, 0, 1, 3};
    bus.req_i = 4'hF; bus.we_i = '0;
    bus.valid_extmem = 1'b0; bus.data_extmem = '0;
    for (int k = 0; k < N; k++) begin
      bus.addr_i[k*32 +: 32]  = 32'h1000 + 32'(k);
      bus.wdata_i[k*32 +: 32] = 32'h5000 + 32'(k);
    end

    // 1. Reset held 5 cycles with all requests high.
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_gnt",  64'(bus.gnt_o), 64'(0));
      chk("rst_req",  64'(bus.request_extmem), 64'(0));
      chk("rst_busy", 64'(bus.busy_o), 64'(0));
    end
    rst = 1'b1;
    wait_gnt(w);
    chk("first_gnt_req0", 64'(bus.gnt_o), 64'(4'b0001));
    bus.req_i = '0;
    @(negedge clk); bus.valid_extmem = 1'b1; bus.data_extmem = 32'h1111;
    @(negedge clk); bus.valid_extmem = 1'b0;
    chk("t1_rvalid", 64'(bus.rvalid_o), 64'(4'b0001));
    chk("t1_rdata",  64'(bus.rdata_o),  64'(32'h1111));

    // 2. Single read from requester 1.
    bus.addr_i[1*32 +: 32] = 32'h0020_0005;
    bus.req_i = 4'b0010;
    wait_gnt(w);
    chk("t2_gnt",      64'(bus.gnt_o), 64'(4'b0010));
    chk("t2_mdl_gnt",  64'(e_gnt),     64'(4'b0010));
    chk("t2_addr",     64'(bus.addr_extmem), 64'(32'h0020_0005));
    chk("t2_req",      64'(bus.request_extmem), 64'(1));
    bus.req_i = '0;
    @(negedge clk); bus.valid_extmem = 1'b1; bus.data_extmem = 32'hABCD;
    chk("t2_no_early_rvalid", 64'(bus.rvalid_o), 64'(0));
    @(negedge clk); bus.valid_extmem = 1'b0;
    chk("t2_rvalid",   64'(bus.rvalid_o), 64'(4'b0010));
    chk("t2_rdata",    64'(bus.rdata_o),  64'(32'hABCD));
    chk("t2_busy",     64'(bus.busy_o),   64'(0));
    chk("t2_req_drop", 64'(bus.request_extmem), 64'(0));
    @(negedge clk);
    chk("t2_rdata_hold", 64'(bus.rdata_o), 64'(32'hABCD));

    // 3. Round-robin with requests 0,1,3 held (ptr reset to 0 first).
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    bus.req_i = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(w);
      chk("rr_order", 64'(w), 64'(order[k]));
      @(negedge clk); bus.valid_extmem = 1'b1; bus.data_extmem = 32'h100 + 32'(k);
      @(negedge clk); bus.valid_extmem = 1'b0;
      chk("rr_rvalid", 64'(bus.rvalid_o), 64'(4'b0001 << order[k]));
      chk("rr_rdata",  64'(bus.rdata_o),  64'(32'h100 + 32'(k)));
    end
    bus.req_i = '0;

    // 4. Posted write from requester 3, then a read queued behind it.
    bus.addr_i[3*32 +: 32]  = 32'h0040_0010;
    bus.wdata_i[3*32 +: 32] = 32'h1234;
    bus.we_i = 4'b1000;
    bus.req_i = 4'b1000;
    wait_gnt(w);
    chk("t4_gnt",   64'(bus.gnt_o), 64'(4'b1000));
    chk("t4_req",   64'(bus.request_extmem), 64'(1));
    chk("t4_wr",    64'(bus.write_extmem), 64'(1));
    chk("t4_addr",  64'(bus.addr_extmem), 64'(32'h0040_0010));
    chk("t4_wdata", 64'(bus.w_data), 64'(32'h1234));
    bus.we_i = '0;
    bus.req_i = 4'b0001;
    @(negedge clk);
    chk("t4_req_one_cycle", 64'(bus.request_extmem), 64'(0));
    chk("t4_wr_one_cycle",  64'(bus.write_extmem), 64'(0));
    chk("t4_no_rvalid",     64'(bus.rvalid_o), 64'(0));
    @(negedge clk);
    chk("t4_next_gnt", 64'(bus.gnt_o), 64'(4'b0001));

    // 5. Reset while the read is outstanding; late valid must be dropped.
    bus.req_i = '0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; bus.valid_extmem = 1'b1; bus.data_extmem = 32'hDEAD;
    @(negedge clk); bus.valid_extmem = 1'b0;
    chk("t5_no_rvalid", 64'(bus.rvalid_o), 64'(0));
    chk("t5_req",       64'(bus.request_extmem), 64'(0));
    chk("t5_busy",      64'(bus.busy_o), 64'(0));
    chk("t5_rdata",     64'(bus.rdata_o), 64'(0));

`ifdef EXTMEM_ARB_TIMEOUT_EN
    // 6. Read with no response times out after TO cycles.
    bus.req_i = 4'b0100;
    wait_gnt(w);
    chk("t6_gnt", 64'(bus.gnt_o), 64'(4'b0100));
    bus.req_i = '0;
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      chk("t6_waiting_rvalid", 64'(bus.rvalid_o), 64'(0));
      chk("t6_waiting_req",    64'(bus.request_extmem), 64'(1));
    end
    @(negedge clk);
    chk("t6_rvalid", 64'(bus.rvalid_o), 64'(4'b0100));
    chk("t6_rerr",   64'(bus.rerr_o),   64'(1));
    chk("t6_rdata",  64'(bus.rdata_o),  64'(0));
    chk("t6_req",    64'(bus.request_extmem), 64'(0));
    bus.valid_extmem = 1'b1; bus.data_extmem = 32'hBEEF;
    repeat (2) begin
      @(negedge clk);
      chk("t6_late_valid_ignored", 64'(bus.rvalid_o), 64'(0));
    end
    bus.valid_extmem = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
